// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by an internal TX FIFO. The frame format (5..DATA_WIDTH data bits,
// optional parity, 1 or 2 stop bits) is latched when each frame starts.
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        baud_tick,
  input  logic                        wr_valid,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  output logic                        wr_ready,
  input  logic [3:0]                  cfg_data_bits,
  input  logic                        cfg_parity_en,
  input  logic                        cfg_parity_odd,
  input  logic                        cfg_stop2,
  output logic                        tx,
  output logic                        tx_busy,
  output logic                        tx_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [3:0] MIN_BITS = 4'd5;
  localparam logic [3:0] MAX_BITS = 4'(DATA_WIDTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP1  = 3'd4;
  localparam logic [2:0] S_STOP2  = 3'd5;

  function automatic logic [3:0] clamp_bits(input logic [3:0] req);
    if (req < MIN_BITS) return MIN_BITS;
    if (req > MAX_BITS) return MAX_BITS;
    return req;
  endfunction

  // Parity covers only the low n bits; the odd flag seeds the XOR chain.
  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d,
                                       input logic [3:0] n,
                                       input logic odd);
    logic p;
    p = odd;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (4'(i) < n) p = p ^ d[i];
    end
    return p;
  endfunction

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;

  logic [2:0]            state;
  logic [3:0]            bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic [3:0]            nbits_q;
  logic                  par_en_q;
  logic                  stop2_q;
  logic                  par_q;
  logic                  last_bit;
  logic                  frame_end;
  logic                  shift_en;

  assign fifo_empty = (fifo_level == '0);
  assign wr_ready   = (fifo_level != FULL_LVL);
  assign push       = wr_valid && wr_ready;
  assign last_bit   = (bit_cnt == (nbits_q - 4'd1));

  always_comb begin
    frame_end = 1'b0;
    if (state == S_STOP2) begin
      frame_end = 1'b1;
    end else if ((state == S_STOP1) && !stop2_q) begin
      frame_end = 1'b1;
    end
  end

  // A frame is only ever started from IDLE or from the tick that closes the previous frame.
  assign pop      = baud_tick && !fifo_empty && ((state == S_IDLE) || frame_end);
  assign shift_en = baud_tick && ((state == S_START) || ((state == S_DATA) && !last_bit));

  // ---- FIFO storage and pointers ----
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // ---- frame datapath: loaded on pop, shifted LSB-first ----
  always_ff @(posedge clk) begin
    if (pop) begin
      shreg    <= mem[rd_ptr];
      nbits_q  <= clamp_bits(cfg_data_bits);
      par_en_q <= cfg_parity_en;
      stop2_q  <= cfg_stop2;
      par_q    <= calc_parity(mem[rd_ptr], clamp_bits(cfg_data_bits), cfg_parity_odd);
    end else if (shift_en) begin
      shreg <= shreg >> 1;
    end
  end

  // ---- frame sequencer ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (baud_tick) begin
        case (state)
          S_IDLE: begin
            if (pop) begin
              state   <= S_START;
              tx      <= 1'b0;
              tx_busy <= 1'b1;
            end
          end
          S_START: begin
            state   <= S_DATA;
            tx      <= shreg[0];
            bit_cnt <= '0;
          end
          S_DATA: begin
            if (last_bit) begin
              if (par_en_q) begin
                state <= S_PARITY;
                tx    <= par_q;
              end else begin
                state <= S_STOP1;
                tx    <= 1'b1;
              end
            end else begin
              tx      <= shreg[0];
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          S_PARITY: begin
            state <= S_STOP1;
            tx    <= 1'b1;
          end
          S_STOP1, S_STOP2: begin
            if (frame_end) begin
              tx_done <= 1'b1;
              if (pop) begin
                state <= S_START;
                tx    <= 1'b0;
              end else begin
                state   <= S_IDLE;
                tx      <= 1'b1;
                tx_busy <= 1'b0;
              end
            end else begin
              state <= S_STOP2;
              tx    <= 1'b1;
            end
          end
          default: begin
            state   <= S_IDLE;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
